// File: rtl/hann_window_apply.sv
// Streaming Hann window: multiplies each signed sample by the coefficient at its
// in-frame index, read from a single-port RAM that the host also writes through us.
module hann_window_apply #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  coef_wr_en,
  input  logic [ADDR_WIDTH-1:0] coef_addr,
  input  logic [DATA_WIDTH-1:0] coef_data,
  output logic                  coef_wr_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int PW = 2 * DATA_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] idx_q, idx_d, idx_use;
  logic                  v1_q, v1_d, sop_s1_q, sop_s1_d, eop_s1_q, eop_s1_d;
  logic [DATA_WIDTH-1:0] data_s1_q, data_s1_d;
  logic                  v2_q, v2_d, sop_s2_q, sop_s2_d, eop_s2_q, eop_s2_d;
  logic signed [PW-1:0]  prod_q, prod_d;
  logic                  out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  coef_wr_err_q, coef_wr_err_d;

  // Index selection and RAM port arbitration: a strobed sample always owns the port.
  always_comb begin
    idx_use     = in_sop ? '0 : idx_q;
    idx_d       = idx_q;
    ram_addr    = idx_q;
    ram_wr_en   = 1'b0;
    ram_wr_data = '0;
    if (in_valid) begin
      idx_d    = idx_use + ADDR_WIDTH'(1);
      ram_addr = idx_use;
    end else if (coef_wr_en) begin
      ram_addr    = coef_addr;
      ram_wr_en   = 1'b1;
      ram_wr_data = coef_data;
    end else begin
      ram_addr = idx_q;
    end
    coef_wr_err_d = coef_wr_en & in_valid;
  end

  // Pipeline next-state: S1 holds the sample while the RAM read completes,
  // S2 holds the full-precision product, the output stage rounds half-up.
  always_comb begin
    v1_d      = in_valid;
    data_s1_d = data_s1_q;
    sop_s1_d  = sop_s1_q;
    eop_s1_d  = eop_s1_q;
    if (in_valid) begin
      data_s1_d = in_data;
      sop_s1_d  = (idx_use == '0);
      eop_s1_d  = (idx_use == '1);
    end else begin
      data_s1_d = data_s1_q;
    end

    v2_d     = v1_q;
    prod_d   = prod_q;
    sop_s2_d = sop_s2_q;
    eop_s2_d = eop_s2_q;
    if (v1_q) begin
      prod_d   = PW'($signed(data_s1_q)) * PW'($signed({1'b0, ram_rd_data}));
      sop_s2_d = sop_s1_q;
      eop_s2_d = eop_s1_q;
    end else begin
      prod_d = prod_q;
    end

    out_valid_d = v2_q;
    out_sop_d   = v2_q & sop_s2_q;
    out_eop_d   = v2_q & eop_s2_q;
    out_data_d  = out_data_q;
    if (v2_q) begin
      // Coefficient is below 1.0, so the rounded result always fits.
      out_data_d = DATA_WIDTH'((prod_q + PW'(33'sh8000)) >>> DATA_WIDTH);
    end else begin
      out_data_d = out_data_q;
    end
  end

  // State registers; reset discards any in-flight samples.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      idx_q         <= '0;
      v1_q          <= 1'b0;
      data_s1_q     <= '0;
      sop_s1_q      <= 1'b0;
      eop_s1_q      <= 1'b0;
      v2_q          <= 1'b0;
      prod_q        <= '0;
      sop_s2_q      <= 1'b0;
      eop_s2_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_data_q    <= '0;
      coef_wr_err_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      v1_q          <= v1_d;
      data_s1_q     <= data_s1_d;
      sop_s1_q      <= sop_s1_d;
      eop_s1_q      <= eop_s1_d;
      v2_q          <= v2_d;
      prod_q        <= prod_d;
      sop_s2_q      <= sop_s2_d;
      eop_s2_q      <= eop_s2_d;
      out_valid_q   <= out_valid_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_data_q    <= out_data_d;
      coef_wr_err_q <= coef_wr_err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign out_data    = out_data_q;
  assign coef_wr_err = coef_wr_err_q;

endmodule
